// File: rtl/stack_writeback_pkg.sv
// Shared definitions for the stack writeback engine: opcodes, FSM encoding,
// call instruction length and opcode classification helpers.
package stack_writeback_pkg;

  localparam logic [7:0] OP_PUSH_EBP    = 8'h55;
  localparam logic [7:0] OP_MOV_EBP_ESP = 8'h89;
  localparam logic [7:0] OP_MOV_EAX_IMM = 8'hb8;
  localparam logic [7:0] OP_POP_EBP     = 8'h5d;
  localparam logic [7:0] OP_RET         = 8'hc3;
  localparam logic [7:0] OP_CALL        = 8'he8;

  // Byte length of a call instruction; eip + CALL_LEN is the return address.
  localparam logic [31:0] CALL_LEN = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Opcodes that need a data-memory transaction after EXEC.
  function automatic logic is_mem_op(input logic [7:0] op);
    return (op == OP_PUSH_EBP) || (op == OP_POP_EBP) ||
           (op == OP_RET)      || (op == OP_CALL);
  endfunction

  // Every opcode this block knows how to retire.
  function automatic logic is_known_op(input logic [7:0] op);
    return is_mem_op(op) || (op == OP_MOV_EBP_ESP) || (op == OP_MOV_EAX_IMM);
  endfunction

endpackage

// File: rtl/stack_mem_port.sv
// Memory request port: latches one request on launch, holds address, data and
// direction stable while mem_req is high, and reports acceptance.
module stack_mem_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        launch_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        accept_o
);

  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Request register: set on launch, cleared on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: address/data are visible outputs with a defined reset value, so
    // they are reset along with the control bits; reset drops any pending
    // request without completing the handshake.
    if (!rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (req_q && mem_ready_i) begin
      req_q <= 1'b0;
    end else if (launch_i && !req_q) begin
      req_q   <= 1'b1;
      we_q    <= we_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  assign accept_o    = req_q && mem_ready_i;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/stack_writeback.sv
// Writeback and stack engine: retires one ALU opcode/result per start pulse,
// updating eax/esp/ebp/eip and sequencing the memory half of push/pop/call/ret.
module stack_writeback
  import stack_writeback_pkg::*;
#(
  parameter logic [31:0] ESP_RESET = 32'h0000_0100,
  parameter logic [31:0] EIP_RESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] ope,
  input  logic [31:0] immidiate_data,
  input  logic [31:0] alu_result_bus,
  output logic [31:0] registor_out,
  output logic [31:0] eax,
  output logic [31:0] esp,
  output logic [31:0] ebp,
  output logic [31:0] eip,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  state_t      state_q;
  logic [7:0]  op_q;
  logic [31:0] imm_q;
  logic [31:0] alu_q;
  logic        busy_q;
  logic        done_q;
  logic        illegal_q;

  logic [31:0] eax_q, esp_q, ebp_q, eip_q;
  logic [31:0] eax_d, esp_d, ebp_d, eip_d;

  logic        launch;
  logic        launch_we;
  logic [31:0] launch_addr;
  logic [31:0] launch_wdata;
  logic        mem_accept;

  // Only the opcode byte of the instruction word is meaningful here.
  logic unused_ope;
  assign unused_ope = ^ope[23:0];

  // Sequencer FSM with registered busy/done/illegal strobes and operand capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_EXEC;
            op_q    <= ope[31:24];
            imm_q   <= immidiate_data;
            alu_q   <= alu_result_bus;
            busy_q  <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (is_mem_op(op_q)) begin
            state_q <= ST_MEM;
          end else begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            illegal_q <= !is_known_op(op_q);
          end
        end
        ST_MEM: begin
          if (mem_accept) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Next-state register values and the memory request launched from EXEC.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    eax_d        = eax_q;
    esp_d        = esp_q;
    ebp_d        = ebp_q;
    eip_d        = eip_q;
    launch       = 1'b0;
    launch_we    = 1'b0;
    launch_addr  = '0;
    launch_wdata = '0;

    if (state_q == ST_EXEC) begin
      case (op_q)
        OP_PUSH_EBP: begin
          // The push address is the already-updated stack pointer.
          esp_d        = alu_q;
          launch       = 1'b1;
          launch_we    = 1'b1;
          launch_addr  = alu_q;
          launch_wdata = ebp_q;
        end
        OP_MOV_EBP_ESP: ebp_d = esp_q;
        OP_MOV_EAX_IMM: eax_d = imm_q;
        OP_CALL: begin
          esp_d        = esp_q - 32'd1;
          launch       = 1'b1;
          launch_we    = 1'b1;
          launch_addr  = esp_q - 32'd1;
          launch_wdata = eip_q + CALL_LEN;
        end
        OP_POP_EBP, OP_RET: begin
          launch      = 1'b1;
          launch_addr = esp_q;
        end
        default: ;
      endcase
    end else if (state_q == ST_MEM && mem_accept) begin
      case (op_q)
        OP_CALL: eip_d = eip_q + CALL_LEN + imm_q;
        OP_POP_EBP: begin
          ebp_d = mem_rdata;
          esp_d = esp_q + 32'd1;
        end
        OP_RET: begin
          eip_d = mem_rdata;
          esp_d = esp_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // Architectural register file.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eax_q <= '0;
      esp_q <= ESP_RESET;
      ebp_q <= '0;
      eip_q <= EIP_RESET;
    end else begin
      eax_q <= eax_d;
      esp_q <= esp_d;
      ebp_q <= ebp_d;
      eip_q <= eip_d;
    end
  end

  stack_mem_port u_mem_port (
    .clk         (clock),
    .rst_n       (reset_n),
    .launch_i    (launch),
    .we_i        (launch_we),
    .addr_i      (launch_addr),
    .wdata_i     (launch_wdata),
    .mem_ready_i (mem_ready),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .accept_o    (mem_accept)
  );

  assign registor_out = esp_q;
  assign eax          = eax_q;
  assign esp          = esp_q;
  assign ebp          = ebp_q;
  assign eip          = eip_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign illegal      = illegal_q;

endmodule
